mem_ctrl: RTL and testbench
===========================

MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 SHALL provide parameter RAM_ADDR_W, default 17: width of the byte-RAM address bus; it takes the low bits of the 32-bit request address.
REQ-002 SHALL have port clk, input, 1: rising-edge clock.
REQ-003 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-004 SHALL have port if_ce, input, 1: instruction-fetch request, held high until done or cancel.
REQ-005 SHALL have port if_raddr, input, 32: fetch byte address.
REQ-006 SHALL have port cancel, input, 1: abort the pending or in-flight fetch (branch taken).
REQ-007 SHALL have port if_mem_ctrl_done, output, 1: one-cycle fetch-complete pulse.
REQ-008 SHALL have port rdata, output, 32: fetched instruction, little-endian.
REQ-009 SHALL have port mem_req, input, 1: data access request, held until mem_done.
REQ-010 SHALL have port mem_we, input, 1: 1 = write, 0 = read.
REQ-011 SHALL have port mem_addr, input, 32: data byte address.
REQ-012 SHALL have port mem_width, input, 2: access size; 0 = byte, 1 = half, 2 or 3 = word.
REQ-013 SHALL have port mem_wdata, input, 32: write data, byte 0 at bits 7:0.
REQ-014 SHALL have port mem_done, output, 1: one-cycle data-access-complete pulse.
REQ-015 SHALL have port mem_rdata, output, 32: read data, zero-extended.
REQ-016 SHALL have port ram_a, output, RAM_ADDR_W: byte RAM address.
REQ-017 SHALL have port ram_wr, output, 1: byte RAM write enable.
REQ-018 SHALL have port ram_dout, output, 8: byte RAM write data.
REQ-019 SHALL have port ram_din, input, 8: byte RAM read data, valid one cycle after ram_a.

Function
REQ-020 SHALL implement states IDLE, IF_RD, MEM_RD, MEM_WR and DONE.
REQ-021 In IDLE, an edge with mem_req=1 SHALL accept the data access; an edge with only if_ce=1 and cancel=0 SHALL accept the fetch; data access wins when both are high.
REQ-022 At acceptance SHALL latch the address, byte count n (1, 2 or 4), write data and source; the latched values, not the live inputs, drive the transaction.
REQ-023 Byte k (k = 0..n-1) SHALL be addressed at ram_a = latched address + k, driven in cycle k+1 after the accept edge; the address wraps modulo 2^32 before truncation.
REQ-024 On reads, ram_wr SHALL be 0, and ram_din byte k SHALL be captured into bits 8k+7:8k at the end of cycle k+2.
REQ-025 Result bits above 8n SHALL be 0.
REQ-026 On writes, ram_wr SHALL be 1 with ram_dout = mem_wdata[8k+7:8k] in cycle k+1; at all other times ram_wr = 0.
REQ-027 The block SHALL enter DONE so that the done pulse is high in cycle n+1 after the accept edge, for reads and writes alike.
REQ-028 In DONE, exactly one of if_mem_ctrl_done or mem_done SHALL be 1, matching the source.
REQ-029 rdata or mem_rdata SHALL be valid in the DONE cycle and SHALL hold until the next completion of the same source.
REQ-030 DONE SHALL always go to IDLE; requests present during DONE SHALL NOT be accepted, which gives requesters one edge to update their address.
REQ-031 Word fetch latency SHALL be accept edge to done = 5 cycles; back-to-back word throughput SHALL be 1 per 6 cycles.
REQ-032 cancel=1 during IF_RD SHALL return the block to IDLE at the next edge with no if_mem_ctrl_done pulse and rdata unchanged.
REQ-033 cancel SHALL have no effect on MEM_RD or MEM_WR.
REQ-034 cancel=1 coinciding with the fetch's DONE cycle SHALL still produce the pulse; the requester discards it.
REQ-035 No new request SHALL be accepted while a transaction is in flight; the other requester waits with its request held.
REQ-036 Address misalignment SHALL be legal and handled bytewise.

Reset
REQ-037 While rst=1 at an edge, the state SHALL become IDLE, and if_mem_ctrl_done, mem_done and ram_wr SHALL become 0.
REQ-038 While rst=1 at an edge, rdata, mem_rdata, ram_a and ram_dout SHALL become 0.
REQ-039 rst SHALL abort any in-flight transaction at the next edge with no done pulse and no further RAM writes.

Verification
REQ-040 Word fetch: RAM[0x100..0x103] = 13,05,10,00; if_ce=1, if_raddr=0x100 -> ram_a 0x100..0x103 in cycles 1-4, if_mem_ctrl_done in cycle 5, rdata = 0x00100513.
REQ-041 Byte write then half read: mem_we=1, width=0, addr=0x2001, wdata=0xAB -> one ram_wr cycle at 0x2001 with 0xAB and mem_done in cycle 2; then a read with width=1 at 0x2000 where RAM[0x2000]=0x34 -> mem_rdata = 0x0000AB34 in cycle 3.
REQ-042 Contention: if_ce and mem_req rise on the same edge -> the data access completes first, the fetch is accepted after the DONE+IDLE edges, and both pulses occur exactly once.
REQ-043 Cancel: cancel=1 in cycle 2 of a fetch -> IDLE next edge, no done pulse, rdata unchanged; a new fetch is then accepted normally.
REQ-044 Reset mid-write: rst during cycle 2 of a word write -> only bytes 0-1 written, ram_wr=0 afterward, no mem_done, all outputs 0 after the edge.

Source files
------------

// File: rtl/mem_ctrl.sv
// mem_ctrl: arbitrates an instruction-fetch port and a data port onto a
// single byte-wide synchronous RAM, moving 1, 2 or 4 bytes per transaction.
// Latency: accept edge to done pulse is n+1 cycles (word = 5 cycles), one
// DONE cycle then one IDLE cycle between transactions.
// Backpressure: requesters hold if_ce / mem_req until their done pulse; no new
// request is taken while busy or in DONE. Data access wins over fetch.
// Ports:
//   clk, rst                  - clock, synchronous active-high reset
//   if_ce/if_raddr/cancel     - fetch request, byte address, fetch abort
//   if_mem_ctrl_done/rdata    - fetch done pulse and fetched word
//   mem_req/we/addr/width/wdata - data request (width 0=byte,1=half,2/3=word)
//   mem_done/mem_rdata        - data done pulse and zero-extended read data
//   ram_a/ram_wr/ram_dout/ram_din - byte RAM, read data one cycle after ram_a
module mem_ctrl #(
  parameter int RAM_ADDR_W = 17
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_ce,
  input  logic [31:0]           if_raddr,
  input  logic                  cancel,
  output logic                  if_mem_ctrl_done,
  output logic [31:0]           rdata,
  input  logic                  mem_req,
  input  logic                  mem_we,
  input  logic [31:0]           mem_addr,
  input  logic [1:0]            mem_width,
  input  logic [31:0]           mem_wdata,
  output logic                  mem_done,
  output logic [31:0]           mem_rdata,
  output logic [RAM_ADDR_W-1:0] ram_a,
  output logic                  ram_wr,
  output logic [7:0]            ram_dout,
  input  logic [7:0]            ram_din
);

  typedef enum logic [2:0] {IDLE, IF_RD, MEM_RD, MEM_WR, DONE} state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;          // current byte address, full 32 bits so +1 wraps mod 2^32
  logic [1:0]  cnt_q, cnt_d;            // index of the byte currently on ram_a
  logic [1:0]  last_q, last_d;          // n-1
  logic [31:0] wdat_q, wdat_d;          // remaining write bytes, next one in [7:0]
  logic [31:0] buf_q, buf_d;            // read bytes captured so far
  logic        src_mem_q, src_mem_d;
  logic        is_wr_q, is_wr_d;
  logic        ram_wr_q, ram_wr_d;
  logic [7:0]  ram_dout_q, ram_dout_d;
  logic        if_done_q, if_done_d;
  logic        mem_done_q, mem_done_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] mem_rdata_q, mem_rdata_d;
  logic [31:0] merged;

  // The last read byte arrives on ram_din during DONE itself, so the result
  // presented in DONE folds it in combinationally; it is registered at the
  // DONE edge and held from then on.
  assign merged = buf_q | ({24'd0, ram_din} << {cnt_q, 3'b000});

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    cnt_d       = cnt_q;
    last_d      = last_q;
    wdat_d      = wdat_q;
    buf_d       = buf_q;
    src_mem_d   = src_mem_q;
    is_wr_d     = is_wr_q;
    ram_wr_d    = 1'b0;
    ram_dout_d  = ram_dout_q;
    if_done_d   = 1'b0;
    mem_done_d  = 1'b0;
    rdata_d     = rdata_q;
    mem_rdata_d = mem_rdata_q;

    case (state_q)
      IDLE: begin
        if (mem_req) begin
          state_d   = mem_we ? MEM_WR : MEM_RD;
          addr_d    = mem_addr;
          cnt_d     = 2'd0;
          last_d    = (mem_width == 2'd0) ? 2'd0 : (mem_width == 2'd1) ? 2'd1 : 2'd3;
          src_mem_d = 1'b1;
          is_wr_d   = mem_we;
          buf_d     = 32'd0;
          if (mem_we) begin
            ram_wr_d   = 1'b1;
            ram_dout_d = mem_wdata[7:0];
            wdat_d     = {8'd0, mem_wdata[31:8]};
          end
        end else if (if_ce && !cancel) begin
          state_d   = IF_RD;
          addr_d    = if_raddr;
          cnt_d     = 2'd0;
          last_d    = 2'd3;
          src_mem_d = 1'b0;
          is_wr_d   = 1'b0;
          buf_d     = 32'd0;
        end
      end

      IF_RD, MEM_RD: begin
        if (state_q == IF_RD && cancel) begin
          state_d = IDLE;
        end else begin
          // ram_din now carries the byte addressed one cycle earlier
          if (cnt_q != 2'd0) begin
            buf_d = buf_q | ({24'd0, ram_din} << {cnt_q - 2'd1, 3'b000});
          end
          if (cnt_q == last_q) begin
            state_d    = DONE;
            if_done_d  = !src_mem_q;
            mem_done_d = src_mem_q;
          end else begin
            cnt_d  = cnt_q + 2'd1;
            addr_d = addr_q + 32'd1;
          end
        end
      end

      MEM_WR: begin
        if (cnt_q == last_q) begin
          state_d    = DONE;
          mem_done_d = 1'b1;
        end else begin
          cnt_d      = cnt_q + 2'd1;
          addr_d     = addr_q + 32'd1;
          ram_wr_d   = 1'b1;
          ram_dout_d = wdat_q[7:0];
          wdat_d     = {8'd0, wdat_q[31:8]};
        end
      end

      DONE: begin
        state_d = IDLE;
        if (!src_mem_q) begin
          rdata_d = merged;
        end else if (!is_wr_q) begin
          mem_rdata_d = merged;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= 32'd0;
      cnt_q       <= 2'd0;
      last_q      <= 2'd0;
      wdat_q      <= 32'd0;
      buf_q       <= 32'd0;
      src_mem_q   <= 1'b0;
      is_wr_q     <= 1'b0;
      ram_wr_q    <= 1'b0;
      ram_dout_q  <= 8'd0;
      if_done_q   <= 1'b0;
      mem_done_q  <= 1'b0;
      rdata_q     <= 32'd0;
      mem_rdata_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      cnt_q       <= cnt_d;
      last_q      <= last_d;
      wdat_q      <= wdat_d;
      buf_q       <= buf_d;
      src_mem_q   <= src_mem_d;
      is_wr_q     <= is_wr_d;
      ram_wr_q    <= ram_wr_d;
      ram_dout_q  <= ram_dout_d;
      if_done_q   <= if_done_d;
      mem_done_q  <= mem_done_d;
      rdata_q     <= rdata_d;
      mem_rdata_q <= mem_rdata_d;
    end
  end

  assign if_mem_ctrl_done = if_done_q;
  assign mem_done         = mem_done_q;
  assign ram_wr           = ram_wr_q;
  assign ram_dout         = ram_dout_q;
  assign ram_a            = addr_q[RAM_ADDR_W-1:0];
  assign rdata            = (state_q == DONE && !src_mem_q) ? merged : rdata_q;
  assign mem_rdata        = (state_q == DONE && src_mem_q && !is_wr_q) ? merged : mem_rdata_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: directed stimulus for mem_ctrl with a byte RAM model,
// a completion scoreboard (source, data, cycle) and a RAM-write scoreboard.
// Requesters hold their request until the matching done pulse.
module tb_mem_ctrl;
  localparam int AW = 17;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_ce;
  logic [31:0]   if_raddr;
  logic          cancel;
  logic          if_mem_ctrl_done;
  logic [31:0]   rdata;
  logic          mem_req;
  logic          mem_we;
  logic [31:0]   mem_addr;
  logic [1:0]    mem_width;
  logic [31:0]   mem_wdata;
  logic          mem_done;
  logic [31:0]   mem_rdata;
  logic [AW-1:0] ram_a;
  logic          ram_wr;
  logic [7:0]    ram_dout;
  logic [7:0]    ram_din;

  always #5 clk = ~clk;

  mem_ctrl #(.RAM_ADDR_W(AW)) dut (
    .clk(clk), .rst(rst),
    .if_ce(if_ce), .if_raddr(if_raddr), .cancel(cancel),
    .if_mem_ctrl_done(if_mem_ctrl_done), .rdata(rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_width(mem_width), .mem_wdata(mem_wdata),
    .mem_done(mem_done), .mem_rdata(mem_rdata),
    .ram_a(ram_a), .ram_wr(ram_wr), .ram_dout(ram_dout), .ram_din(ram_din)
  );

  // byte RAM: registered read, write on the clock edge
  logic [7:0] ram [0:(1<<AW)-1];
  always @(posedge clk) begin
    ram_din <= ram[ram_a];
    if (ram_wr) ram[ram_a] = ram_dout;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        is_mem;
    logic        chk_dat;
    logic [31:0] dat;
    int          cyc;
  } exp_t;

  typedef struct {
    logic [AW-1:0] a;
    logic [7:0]    d;
  } wr_t;

  exp_t sb[$];
  wr_t  wq[$];
  int   n_chk = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // completion and RAM-write monitor
  exp_t me;
  wr_t  mw;
  always @(negedge clk) begin
    if (if_mem_ctrl_done || mem_done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", {30'd0, if_mem_ctrl_done, mem_done}, 32'd0);
      end else begin
        me = sb.pop_front();
        chk("done_src", {30'd0, if_mem_ctrl_done, mem_done}, me.is_mem ? 32'd1 : 32'd2);
        chk("done_cycle", 32'(cyc), 32'(me.cyc));
        if (me.chk_dat) chk(me.is_mem ? "mem_rdata" : "rdata", me.is_mem ? mem_rdata : rdata, me.dat);
      end
    end
    if (ram_wr) begin
      if (wq.size() == 0) begin
        chk("unexpected_ram_wr", {31'd0, ram_wr}, 32'd0);
      end else begin
        mw = wq.pop_front();
        chk("ram_wr_addr", 32'(ram_a), 32'(mw.a));
        chk("ram_wr_data", {24'd0, ram_dout}, {24'd0, mw.d});
      end
    end
  end

  // call right after a posedge (#1); accept happens at the next edge
  task automatic start_mem(input logic we, input logic [1:0] w, input logic [31:0] a,
                           input logic [31:0] wd, input logic [31:0] ed, input int extra);
    int n;
    exp_t e;
    wr_t x;
    logic [31:0] ak;
    n = (w == 2'd0) ? 1 : (w == 2'd1) ? 2 : 4;
    mem_req = 1'b1; mem_we = we; mem_width = w; mem_addr = a; mem_wdata = wd;
    e.is_mem = 1'b1; e.chk_dat = !we; e.dat = ed; e.cyc = cyc + 1 + n + extra;
    sb.push_back(e);
    if (we) begin
      for (int k = 0; k < n; k++) begin
        ak = a + 32'(k);
        x.a = ak[AW-1:0];
        x.d = wd[8*k +: 8];
        wq.push_back(x);
      end
    end
  endtask

  task automatic start_fetch(input logic [31:0] a, input logic [31:0] ed, input int extra);
    exp_t e;
    if_ce = 1'b1; if_raddr = a;
    e.is_mem = 1'b0; e.chk_dat = 1'b1; e.dat = ed; e.cyc = cyc + 1 + 4 + extra;
    sb.push_back(e);
  endtask

  task automatic wait_mem();
    bit seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (mem_done) seen = 1'b1;
    end
    if (!seen) chk("mem_done_timeout", {31'd0, mem_done}, 32'd1);
    @(posedge clk); #1;
    mem_req = 1'b0; mem_we = 1'b0;
  endtask

  task automatic wait_fetch();
    bit seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (if_mem_ctrl_done) seen = 1'b1;
    end
    if (!seen) chk("fetch_done_timeout", {31'd0, if_mem_ctrl_done}, 32'd1);
    @(posedge clk); #1;
    if_ce = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_if_done"},  {31'd0, if_mem_ctrl_done}, 32'd0);
    chk({tag, "_mem_done"}, {31'd0, mem_done}, 32'd0);
    chk({tag, "_ram_wr"},   {31'd0, ram_wr}, 32'd0);
    chk({tag, "_ram_a"},    32'(ram_a), 32'd0);
    chk({tag, "_ram_dout"}, {24'd0, ram_dout}, 32'd0);
    chk({tag, "_rdata"},    rdata, 32'd0);
    chk({tag, "_mem_rdata"}, mem_rdata, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; if_ce = 1'b0; if_raddr = 32'd0; cancel = 1'b0;
    mem_req = 1'b0; mem_we = 1'b0; mem_addr = 32'd0; mem_width = 2'd0; mem_wdata = 32'd0;
    ram[17'h00100] = 8'h13; ram[17'h00101] = 8'h05; ram[17'h00102] = 8'h10; ram[17'h00103] = 8'h00;
    ram[17'h00104] = 8'h93; ram[17'h00105] = 8'h00; ram[17'h00106] = 8'h00; ram[17'h00107] = 8'h00;
    ram[17'h00300] = 8'h00; ram[17'h00301] = 8'h00;
    ram[17'h02000] = 8'h34; ram[17'h02001] = 8'h00;
    ram[17'h02FFF] = 8'h11; ram[17'h03000] = 8'h22; ram[17'h03001] = 8'h33; ram[17'h03002] = 8'h44;
    ram[17'h1FFFF] = 8'h5A; ram[17'h00000] = 8'hC3;
    ram[17'h00400] = 8'h11; ram[17'h00401] = 8'h22; ram[17'h00402] = 8'h33; ram[17'h00403] = 8'h44;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // word fetch: ram_a walks 0x100..0x103 in cycles 1-4, done in cycle 5
    start_fetch(32'h100, 32'h00100513, 0);
    @(posedge clk);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("fetch_ram_a", 32'(ram_a), 32'h100 + 32'(k));
      chk("fetch_ram_wr", {31'd0, ram_wr}, 32'd0);
    end
    wait_fetch();
    // back-to-back fetch: 6 cycles between done pulses
    start_fetch(32'h104, 32'h00000093, 0);
    wait_fetch();

    // byte write then half read over it
    start_mem(1'b1, 2'd0, 32'h2001, 32'h000000AB, 32'd0, 0);
    wait_mem();
    start_mem(1'b0, 2'd1, 32'h2000, 32'd0, 32'h0000AB34, 0);
    wait_mem();

    // misaligned word read, and a half read wrapping the 32-bit address
    start_mem(1'b0, 2'd2, 32'h2FFF, 32'd0, 32'h44332211, 0);
    wait_mem();
    start_mem(1'b0, 2'd1, 32'hFFFF_FFFF, 32'd0, 32'h0000C35A, 0);
    wait_mem();

    // width 3 word write, word read back, zero-extended byte read
    start_mem(1'b1, 2'd3, 32'h500, 32'hCAFEF00D, 32'd0, 0);
    wait_mem();
    start_mem(1'b0, 2'd2, 32'h500, 32'd0, 32'hCAFEF00D, 0);
    wait_mem();
    start_mem(1'b0, 2'd0, 32'h502, 32'd0, 32'h000000FE, 0);
    wait_mem();
    chk("rdata_hold", rdata, 32'h00000093);

    // contention: data byte read wins, fetch follows after DONE + IDLE
    start_mem(1'b0, 2'd0, 32'h2001, 32'd0, 32'h000000AB, 0);
    start_fetch(32'h100, 32'h00100513, 1 + 2);
    fork
      wait_mem();
      wait_fetch();
    join

    // cancel in cycle 2 of a fetch
    if_ce = 1'b1; if_raddr = 32'h300;
    @(posedge clk);
    @(posedge clk); #1;
    cancel = 1'b1; if_ce = 1'b0;
    @(posedge clk); #1;
    cancel = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("rdata_after_cancel", rdata, 32'h00100513);
    end
    @(posedge clk); #1;
    start_fetch(32'h104, 32'h00000093, 0);
    wait_fetch();

    // cancel ignored by data reads and writes
    start_mem(1'b0, 2'd2, 32'h2FFF, 32'd0, 32'h44332211, 0);
    cancel = 1'b1;
    wait_mem();
    start_mem(1'b1, 2'd1, 32'h600, 32'h00009988, 32'd0, 0);
    wait_mem();
    cancel = 1'b0;

    // reset in cycle 2 of a word write: only bytes 0 and 1 land
    mem_req = 1'b1; mem_we = 1'b1; mem_width = 2'd2; mem_addr = 32'h400; mem_wdata = 32'hDDCCBBAA;
    begin
      wr_t x;
      x.a = 17'h00400; x.d = 8'hAA; wq.push_back(x);
      x.a = 17'h00401; x.d = 8'hBB; wq.push_back(x);
    end
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b1; mem_req = 1'b0; mem_we = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk_all_zero("midrst");
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    chk("ram_400", {24'd0, ram[17'h00400]}, 32'h000000AA);
    chk("ram_401", {24'd0, ram[17'h00401]}, 32'h000000BB);
    chk("ram_402", {24'd0, ram[17'h00402]}, 32'h00000033);
    chk("ram_403", {24'd0, ram[17'h00403]}, 32'h00000044);
    chk("ram_601", {24'd0, ram[17'h00601]}, 32'h00000099);
    #1;
    start_fetch(32'h100, 32'h00100513, 0);
    wait_fetch();

    repeat (5) @(posedge clk);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    chk("wq_empty", 32'(wq.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
